// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Groups the datapath-facing signals of pipeline_ctrl: the hazard and branch
//   information coming from the ID/EX stages, and the register load enables
//   and flush requests going back to the pipeline.
//
//   Signals
//     i_id_rs, i_id_rt  [4:0]  source registers of the instruction in ID
//     i_ex_rt           [4:0]  destination register of the instruction in EX
//     i_ex_mem_rd              instruction in EX is a load
//     i_ex_take                branch/jump in EX resolved taken
//     o_pc_en, o_if_id_en      PC and IF/ID load enables
//     o_if_id_flush            synchronous clear of IF/ID
//     o_id_ex_flush            synchronous clear of ID/EX
//     o_pipe_en                load enable for ID/EX, EX/MEM, MEM/WB
//
//   Modports
//     slave  : the controller (consumes i_*, produces o_*)
//     master : the pipeline datapath side
interface pipeline_ctrl_if;
    logic [4:0] i_id_rs;
    logic [4:0] i_id_rt;
    logic [4:0] i_ex_rt;
    logic       i_ex_mem_rd;
    logic       i_ex_take;
    logic       o_pc_en;
    logic       o_if_id_en;
    logic       o_if_id_flush;
    logic       o_id_ex_flush;
    logic       o_pipe_en;

    modport slave (
        input  i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_rd, i_ex_take,
        output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en
    );

    modport master (
        output i_id_rs, i_id_rt, i_ex_rt, i_ex_mem_rd, i_ex_take,
        input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Run/step/halt sequencer for a 5-stage pipeline plus load-use hazard and
//   taken-branch handling. Enables and flushes are combinational from the
//   current state and the hazard inputs (zero-cycle latency).
//
//   Optional feature: define PIPE_CTRL_STATS_EN to build saturating stall and
//   flush event counters. Without it both counter outputs are tied to zero and
//   no counter flops exist.
//
//   Ports
//     i_clk        clock, rising edge
//     i_rst        asynchronous active-low reset
//     i_start      leave IDLE
//     i_mode_step  1 = single-step mode, 0 = continuous
//     i_step       step request (level, sampled every cycle)
//     i_halt       HALT reached write-back
//     pipe         pipeline_ctrl_if.slave (hazard inputs, enables/flushes)
//     o_state      current FSM state
//     o_stall_cnt  stall cycle count (NBITS_CNT, saturating)
//     o_flush_cnt  flush cycle count (NBITS_CNT, saturating)
//
//   state     | meaning
//   ----------+----------------------------------------------
//   IDLE      | waiting for i_start, pipeline frozen
//   RUN       | continuous execution
//   STEP_WAIT | single-step mode, pipeline frozen until i_step
//   STEP_EXEC | single-step mode, pipeline advances one cycle
//   HALTED    | HALT retired, frozen until reset
module pipeline_ctrl #(
    parameter int NBITS_CNT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_mode_step,
    input  logic                 i_step,
    input  logic                 i_halt,
    pipeline_ctrl_if.slave       pipe,
    output logic [2:0]           o_state,
    output logic [NBITS_CNT-1:0] o_stall_cnt,
    output logic [NBITS_CNT-1:0] o_flush_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_EXEC = 3'd3,
        HALTED    = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   gen;
    logic   hazard;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = i_mode_step ? STEP_WAIT : RUN;
                end
            end
            RUN: begin
                // halt wins over a concurrent switch to step mode
                if (i_halt) begin
                    state_d = HALTED;
                end else if (i_mode_step) begin
                    state_d = STEP_WAIT;
                end
            end
            STEP_WAIT: begin
                if (!i_mode_step) begin
                    state_d = RUN;
                end else if (i_step) begin
                    state_d = STEP_EXEC;
                end
            end
            STEP_EXEC: begin
                // one cycle only; a held i_step re-steps via STEP_WAIT
                state_d = i_halt ? HALTED : STEP_WAIT;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_state = state_q;
    assign gen     = (state_q == RUN) || (state_q == STEP_EXEC);

    // Load-use hazard; r0 is hardwired zero so it never creates a dependency.
    assign hazard = pipe.i_ex_mem_rd && (pipe.i_ex_rt != 5'd0) &&
                    ((pipe.i_ex_rt == pipe.i_id_rs) || (pipe.i_ex_rt == pipe.i_id_rt));

    // A taken branch flushes the instruction in ID anyway, so it overrides
    // the stall: the front end keeps moving to fetch the target.
    always_comb begin
        pipe.o_pipe_en     = gen;
        pipe.o_if_id_flush = gen & pipe.i_ex_take;
        pipe.o_pc_en       = gen & (pipe.i_ex_take | ~hazard);
        pipe.o_if_id_en    = gen & (pipe.i_ex_take | ~hazard);
        pipe.o_id_ex_flush = gen & (pipe.i_ex_take | hazard);
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [NBITS_CNT-1:0] stall_cnt_q;
    logic [NBITS_CNT-1:0] flush_cnt_q;
    localparam logic [NBITS_CNT-1:0] CNT_ONE = {{(NBITS_CNT-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (gen && hazard && !pipe.i_ex_take && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (gen && pipe.i_ex_take && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NBITS_CNT, default 16, width of the stall and flush counters.
REQ-002 SHALL have port i_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  leaves IDLE.
REQ-005 SHALL have port i_mode_step  input  1  1 = single-step mode, 0 = continuous mode.
REQ-006 SHALL have port i_step  input  1  step request; level sampled each cycle.
REQ-007 SHALL have port i_halt  input  1  HALT instruction reached write-back.
REQ-008 SHALL have ports i_id_rs, i_id_rt  input  5 each  source registers of the instruction in ID.
REQ-009 SHALL have port i_ex_rt  input  5  destination register of the instruction in EX.
REQ-010 SHALL have port i_ex_mem_rd  input  1  instruction in EX is a load.
REQ-011 SHALL have port i_ex_take  input  1  branch/jump in EX resolved taken.
REQ-012 SHALL have ports o_pc_en, o_if_id_en  output  1 each  PC and IF/ID register load enables.
REQ-013 SHALL have ports o_if_id_flush, o_id_ex_flush  output  1 each  synchronous-clear requests for IF/ID and ID/EX registers.
REQ-014 SHALL have port o_pipe_en  output  1  load enable for ID/EX, EX/MEM, MEM/WB.
REQ-015 SHALL have port o_state  output  3  current FSM state.
REQ-016 SHALL have ports o_stall_cnt, o_flush_cnt  output  NBITS_CNT each  event counters.

Function
REQ-017 SHALL implement FSM states IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, HALTED=4, registered and driven on o_state.
REQ-018 SHALL transition IDLE->RUN on i_start with i_mode_step=0, IDLE->STEP_WAIT on i_start with i_mode_step=1.
REQ-019 SHALL transition RUN->STEP_WAIT when i_mode_step=1, STEP_WAIT->RUN when i_mode_step=0.
REQ-020 SHALL transition STEP_WAIT->STEP_EXEC when i_step=1; STEP_EXEC SHALL last exactly one cycle, then return to STEP_WAIT regardless of i_step.
REQ-021 SHALL transition RUN or STEP_EXEC->HALTED when i_halt=1; i_halt SHALL take priority over i_mode_step; HALTED SHALL be left only by reset.
REQ-022 SHALL define gen = (state==RUN or state==STEP_EXEC); all enables/flushes SHALL be 0 when gen=0.
REQ-023 SHALL define hazard = i_ex_mem_rd and i_ex_rt!=0 and (i_ex_rt==i_id_rs or i_ex_rt==i_id_rt), combinational.
REQ-024 SHALL drive o_pipe_en=gen; o_if_id_flush=gen&i_ex_take.
REQ-025 SHALL drive o_pc_en=o_if_id_en=gen&(i_ex_take | ~hazard).
REQ-026 SHALL drive o_id_ex_flush=gen&(i_ex_take | hazard); i_ex_take SHALL take priority over hazard (no stall when taken).
REQ-027 SHALL have zero-cycle latency from hazard/i_ex_take inputs to enable/flush outputs.

Reset
REQ-028 SHALL, while i_rst=0, asynchronously force state IDLE, o_stall_cnt=0, o_flush_cnt=0; all enable/flush outputs SHALL be 0 via gen=0.
REQ-029 SHALL, on reset asserted mid-operation (any state), abandon the operation and restart from IDLE after release.

Configuration
REQ-030 SHALL compile counters only when macro PIPE_CTRL_STATS_EN is defined.
REQ-031 SHALL, with PIPE_CTRL_STATS_EN, increment o_stall_cnt per cycle with gen&hazard&~i_ex_take, o_flush_cnt per cycle with gen&i_ex_take, both saturating at all-ones.
REQ-032 SHALL, without PIPE_CTRL_STATS_EN, tie o_stall_cnt and o_flush_cnt to 0 with no counter flops.

Verification
REQ-033 SHALL cover: reset, i_start=1, i_mode_step=0 -> o_state=1 next cycle, o_pipe_en=o_pc_en=1.
REQ-034 SHALL cover: RUN, i_ex_mem_rd=1, i_ex_rt=5, i_id_rs=5 -> o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_stall_cnt +1; same with i_ex_rt=0 -> no stall.
REQ-035 SHALL cover: RUN, hazard and i_ex_take=1 same cycle -> o_pc_en=1, o_if_id_flush=1, o_id_ex_flush=1, o_flush_cnt +1, o_stall_cnt unchanged.
REQ-036 SHALL cover: step mode, i_step held 3 cycles -> o_state sequence 2,3,2,3; o_pipe_en=1 only in state 3.
REQ-037 SHALL cover: i_halt=1 in RUN -> o_state=4 and all enables 0; i_rst=0 mid-cycle -> o_state=0 immediately, counters 0; NBITS_CNT=2, 5 stall cycles -> o_stall_cnt=3.
